// File: rtl/j_cmpn_match.sv
// Multi-channel masked equality comparator: registered per-channel active-low
// match strobes, first-hit index, sticky flags and saturating hit counters.
module j_cmpn_match #(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int CH_W     = $clog2(CHANNELS)
) (
    input  logic                sys_clk,
    input  logic                resetl,
    input  logic [0:WIDTH-1]    a,
    input  logic                a_valid,
    input  logic                edge_mode,
    input  logic                ld,
    input  logic                ld_sel,
    input  logic [0:CH_W-1]     ld_ch,
    input  logic [0:WIDTH-1]    ld_data,
    input  logic                clr,
    input  logic [0:CH_W-1]     rd_ch,
    output logic [0:CHANNELS-1] match_n,
    output logic                any_match,
    output logic [0:CH_W-1]     first_ch,
    output logic [0:CHANNELS-1] sticky,
    output logic [0:CNT_W-1]    rd_cnt
);

    localparam logic [0:CNT_W-1] CNT_MAX = {CNT_W{1'b1}};

    logic [0:WIDTH-1]    ref_q  [CHANNELS];
    logic [0:WIDTH-1]    ref_d  [CHANNELS];
    logic [0:WIDTH-1]    mask_q [CHANNELS];
    logic [0:WIDTH-1]    mask_d [CHANNELS];
    logic [0:CNT_W-1]    cnt_q  [CHANNELS];
    logic [0:CNT_W-1]    cnt_d  [CHANNELS];
    logic [0:CHANNELS-1] raw_hit_s;
    logic [0:CHANNELS-1] qual_hit_s;
    logic [0:CHANNELS-1] prev_hit_q, prev_hit_d;
    logic [0:CHANNELS-1] match_n_q, match_n_d;
    logic [0:CHANNELS-1] sticky_q, sticky_d;
    logic                any_q, any_d;
    logic [0:CH_W-1]     first_q, first_d;

    // Compare against the pre-load registers; edge mode suppresses run continuations.
    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            raw_hit_s[k]  = a_valid && (((a ^ ref_q[k]) & mask_q[k]) == {WIDTH{1'b0}});
            qual_hit_s[k] = raw_hit_s[k] && !(edge_mode && prev_hit_q[k]);
        end
    end

    // Next-state for programming registers, hit history, strobes and counters.
    always_comb begin
        ref_d  = ref_q;
        mask_d = mask_q;
        if (ld && (int'(ld_ch) < CHANNELS)) begin
            if (ld_sel) begin
                mask_d[ld_ch] = ld_data;
            end else begin
                ref_d[ld_ch] = ld_data;
            end
        end else begin
            ref_d  = ref_q;
            mask_d = mask_q;
        end

        // Invalid cycles neither break nor extend a run.
        prev_hit_d = a_valid ? raw_hit_s : prev_hit_q;
        match_n_d  = ~qual_hit_s;
        any_d      = |qual_hit_s;

        first_d = {CH_W{1'b0}};
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            first_d = qual_hit_s[k] ? CH_W'(k) : first_d;
        end

        sticky_d = clr ? {CHANNELS{1'b0}} : (sticky_q | qual_hit_s);

        for (int k = 0; k < CHANNELS; k++) begin
            if (clr) begin
                cnt_d[k] = {CNT_W{1'b0}};
            end else if (qual_hit_s[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else begin
                cnt_d[k] = cnt_q[k];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            for (int k = 0; k < CHANNELS; k++) begin
                ref_q[k]  <= {WIDTH{1'b0}};
                mask_q[k] <= {WIDTH{1'b1}};
                cnt_q[k]  <= {CNT_W{1'b0}};
            end
            prev_hit_q <= {CHANNELS{1'b0}};
            match_n_q  <= {CHANNELS{1'b1}};
            sticky_q   <= {CHANNELS{1'b0}};
            any_q      <= 1'b0;
            first_q    <= {CH_W{1'b0}};
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                ref_q[k]  <= ref_d[k];
                mask_q[k] <= mask_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
            prev_hit_q <= prev_hit_d;
            match_n_q  <= match_n_d;
            sticky_q   <= sticky_d;
            any_q      <= any_d;
            first_q    <= first_d;
        end
    end

    // Counter readback mux; out-of-range selects read as zero.
    always_comb begin
        if (int'(rd_ch) < CHANNELS) begin
            rd_cnt = cnt_q[rd_ch];
        end else begin
            rd_cnt = {CNT_W{1'b0}};
        end
    end

    assign match_n   = match_n_q;
    assign any_match = any_q;
    assign first_ch  = first_q;
    assign sticky    = sticky_q;

endmodule
